// File: rtl/chip_bridge_pkg.sv
// Shared definitions for the chip bridge send path: channel tags, FSM encoding
// and credit defaults.
package chip_bridge_pkg;

  localparam int CREDIT_MAX_DEF = 8;
  localparam int CREDIT_W_DEF   = 4;

  localparam logic [1:0] CH_IDLE = 2'b00;
  localparam logic [1:0] CH_1    = 2'b01;
  localparam logic [1:0] CH_2    = 2'b10;
  localparam logic [1:0] CH_3    = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } send_state_t;

  // Channel slots are indexed 0..2; the link tag is slot index + 1.
  function automatic logic [1:0] ch_id(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/chip_bridge_send_serializer_if.sv
// Bundle of NoC-side flit handshakes and link-side word/credit signals
// around the send serializer.
interface chip_bridge_send_serializer_if;

  logic [63:0] network_out_1;
  logic [63:0] network_out_2;
  logic [63:0] network_out_3;
  logic        data_out_val_1;
  logic        data_out_val_2;
  logic        data_out_val_3;
  logic        data_out_rdy_1;
  logic        data_out_rdy_2;
  logic        data_out_rdy_3;
  logic [31:0] intcnct_data_out;
  logic [1:0]  intcnct_channel_out;
  logic [2:0]  intcnct_credit_back_out;
  logic        credit_err;

  modport master (
    output network_out_1, network_out_2, network_out_3,
    output data_out_val_1, data_out_val_2, data_out_val_3,
    output intcnct_credit_back_out,
    input  data_out_rdy_1, data_out_rdy_2, data_out_rdy_3,
    input  intcnct_data_out, intcnct_channel_out, credit_err
  );

  modport slave (
    input  network_out_1, network_out_2, network_out_3,
    input  data_out_val_1, data_out_val_2, data_out_val_3,
    input  intcnct_credit_back_out,
    output data_out_rdy_1, data_out_rdy_2, data_out_rdy_3,
    output intcnct_data_out, intcnct_channel_out, credit_err
  );

endinterface

// File: rtl/chip_bridge_send_serializer_credit_cnt.sv
// Per-channel flit credit counter: starts full, decrements on grant,
// increments on a returned credit, and flags a return that would exceed full.
module bridge_credit_cnt #(
  parameter int CREDIT_MAX = 8,
  parameter int CREDIT_W   = 4
) (
  input  logic chip_clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic overflow
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(CREDIT_MAX);

  logic [CREDIT_W-1:0] cnt;

  // Simultaneous return and grant cancel; a return at full is dropped.
  always_ff @(posedge chip_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= FULL;
    end else if (inc && !dec && cnt != FULL) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign nonzero  = (cnt != '0);
  assign overflow = inc && !dec && (cnt == FULL);

endmodule

// File: rtl/chip_bridge_send_serializer.sv
// Send-side serializer: three buffered 64-bit flit channels, round-robin
// arbitration under credit control, two 32-bit tagged words per flit.
module chip_bridge_send_serializer
  import chip_bridge_pkg::*;
#(
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int CREDIT_W   = CREDIT_W_DEF
) (
  input logic                          chip_clk,
  input logic                          rst_n,
  chip_bridge_send_serializer_if.slave br
);

  logic [2:0]  flit_val;
  logic [63:0] flit_in [3];
  logic [2:0]  hold_vld;
  logic [63:0] hold_data [3];
  logic [2:0]  credit_ok;
  logic [2:0]  credit_ovf;
  logic [2:0]  grant_dec;
  logic [2:0]  elig;

  send_state_t state, state_nxt;
  logic [63:0] send_reg;
  logic [1:0]  send_ch;
  logic [1:0]  last_idx;
  logic [31:0] data_q, data_nxt;
  logic [1:0]  chan_q, chan_nxt;
  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic        load;
  logic        err_q;

  assign flit_val   = {br.data_out_val_3, br.data_out_val_2, br.data_out_val_1};
  assign flit_in[0] = br.network_out_1;
  assign flit_in[1] = br.network_out_2;
  assign flit_in[2] = br.network_out_3;

  // A slot frees on the edge its flit is granted, so it cannot also accept then.
  always_ff @(posedge chip_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= '0;
      for (int i = 0; i < 3; i++) hold_data[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (grant_dec[i]) begin
          hold_vld[i] <= 1'b0;
        end else if (flit_val[i] && !hold_vld[i]) begin
          hold_vld[i]  <= 1'b1;
          hold_data[i] <= flit_in[i];
        end
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_credit
    bridge_credit_cnt #(
      .CREDIT_MAX(CREDIT_MAX),
      .CREDIT_W  (CREDIT_W)
    ) u_credit (
      .chip_clk(chip_clk),
      .rst_n   (rst_n),
      .inc     (br.intcnct_credit_back_out[g]),
      .dec     (grant_dec[g]),
      .nonzero (credit_ok[g]),
      .overflow(credit_ovf[g])
    );
  end

  assign elig = hold_vld & credit_ok;

  // Round-robin search beginning at the slot after the last granted one.
  always_comb begin
    logic [1:0] cand;
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = next_idx(last_idx);
    for (int k = 0; k < 3; k++) begin
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
      cand = next_idx(cand);
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    chan_nxt  = chan_q;
    load      = 1'b0;
    case (state)
      IDLE, SEND_LO: begin
        if (grant_vld) begin
          load      = 1'b1;
          data_nxt  = hold_data[grant_idx][63:32];
          chan_nxt  = ch_id(grant_idx);
          state_nxt = SEND_HI;
        end else begin
          data_nxt  = '0;
          chan_nxt  = CH_IDLE;
          state_nxt = IDLE;
        end
      end
      SEND_HI: begin
        data_nxt  = send_reg[31:0];
        chan_nxt  = send_ch;
        state_nxt = SEND_LO;
      end
      default: begin
        data_nxt  = '0;
        chan_nxt  = CH_IDLE;
        state_nxt = IDLE;
      end
    endcase
  end

  assign grant_dec = load ? (3'b001 << grant_idx) : 3'b000;

  always_ff @(posedge chip_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= '0;
      chan_q   <= CH_IDLE;
      send_reg <= '0;
      send_ch  <= CH_IDLE;
      last_idx <= 2'd2;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      chan_q <= chan_nxt;
      err_q  <= err_q | (|credit_ovf);
      if (load) begin
        send_reg <= hold_data[grant_idx];
        send_ch  <= ch_id(grant_idx);
        last_idx <= grant_idx;
      end
    end
  end

  assign br.data_out_rdy_1      = ~hold_vld[0];
  assign br.data_out_rdy_2      = ~hold_vld[1];
  assign br.data_out_rdy_3      = ~hold_vld[2];
  assign br.intcnct_data_out    = data_q;
  assign br.intcnct_channel_out = chan_q;
  assign br.credit_err          = err_q;

endmodule

// File: doc/chip_bridge_send_serializer.md
Name: chip_bridge_send_serializer

Overview:
Send-side stage that feeds the chip bridge interconnect link. It takes three 64-bit NoC output channels with valid/ready handshakes, buffers one flit per channel, and arbitrates round-robin among them. The winning flit is sent as two 32-bit words on intcnct_data_out, tagged with a 2-bit channel id. Per-channel credit counters, replenished by intcnct_credit_back_out pulses from the far side, prevent receiver overflow.

Parameters:
CREDIT_MAX, 8, initial and maximum credits per channel, in flits
CREDIT_W, 4, credit counter width; must hold CREDIT_MAX

Ports:
chip_clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
network_out_1  in  64  channel 1 flit
network_out_2  in  64  channel 2 flit
network_out_3  in  64  channel 3 flit
data_out_val_1  in  1  channel 1 flit valid
data_out_val_2  in  1  channel 2 flit valid
data_out_val_3  in  1  channel 3 flit valid
data_out_rdy_1  out  1  channel 1 holding register empty
data_out_rdy_2  out  1  channel 2 holding register empty
data_out_rdy_3  out  1  channel 3 holding register empty
intcnct_data_out  out  32  serialized word
intcnct_channel_out  out  2  word tag: 00 idle, 01 ch1, 10 ch2, 11 ch3
intcnct_credit_back_out  in  3  bit i-1 = one-cycle pulse returning one flit credit for channel i
credit_err  out  1  sticky credit overflow flag

Behaviour:
- Clocking and reset: one clock, chip_clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - intcnct_data_out = 0, intcnct_channel_out = 00, credit_err = 0
  - data_out_rdy_N = 1; holding registers empty
  - credits = CREDIT_MAX
  - FSM = IDLE; round-robin pointer = ch3, so ch1 has first priority
- Input handshake:
  - data_out_rdy_N is a registered output equal to "holding register N empty".
  - A flit is accepted on an edge where val && rdy.
  - The holding register clears on the edge the flit is granted, so rdy rises the following cycle.
- Eligibility: channel N is eligible when its holding register is valid and its credit > 0.
- Arbitration:
  - Round-robin; search starts at the channel after the last granted one, wrapping 3 -> 1.
  - The grant is evaluated combinationally in IDLE or SEND_LO.
- FSM states:
  - IDLE, no grant: drive channel 00, data 0.
  - IDLE or SEND_LO, with grant: on the next edge, copy the flit into the 64-bit send register, register word [63:32] with channel id, decrement that channel's credit, update the pointer, go to SEND_HI.
  - SEND_HI: on the next edge, register word [31:0] with the same channel id, go to SEND_LO.
  - SEND_LO, with grant: start the next flit (back-to-back, no idle bubble).
  - SEND_LO, no grant: drive 00 / 0, go to IDLE.
- Latency: a flit accepted at edge k has its HI word registered at edge k+1 and its LO word at edge k+2. Peak rate is one flit per 2 cycles.
- Credits:
  - A credit_back pulse increments the channel's counter; a grant decrements it.
  - Pulse and grant in the same cycle: counter unchanged.
  - A pulse with the counter already at CREDIT_MAX and no grant: counter holds and credit_err sets. credit_err clears only on reset.
  - A counter at 0 blocks that channel only; other channels continue.
- Once started, a flit is always completed; a flit is never split across other channels' words.
- Reset asserted mid-flit: the word stream aborts immediately, all state returns to reset values, and the partially sent flit is lost.

Decomposition:
- Package chip_bridge_pkg holds:
  - channel id constants CH_IDLE = 2'b00, CH_1 = 2'b01, CH_2 = 2'b10, CH_3 = 2'b11
  - FSM state encoding (IDLE, SEND_HI, SEND_LO)
  - CREDIT_MAX default
- Sub-module bridge_credit_cnt (inc pulse, dec pulse, nonzero, overflow), instantiated three times.
- Arbiter and FSM stay in the top module.

Test Plan:
- Reset -> rdy_1..3 = 1, channel_out = 00, data_out = 0, credit_err = 0.
- Single ch1 flit 64'hDEADBEEF_01234567 accepted at edge k -> edge k+1: {01, DEADBEEF}; edge k+2: {01, 01234567}; then 00; rdy_1 high again by edge k+2.
- All three channels valid together, every cycle -> words tagged 01,01,10,10,11,11,01,... with no idle gaps; grants follow strict rotation.
- Ch2 sends 8 flits with no credit returns -> 9th flit stalls in its holding register (rdy_2 = 0) while ch1 traffic still flows; one credit_back[1] pulse -> stalled flit's HI word appears 1 cycle later.
- Credit pulse coincides with the grant on ch3 at credit 1 -> counter remains 1; extra pulse at CREDIT_MAX -> credit_err = 1 and stays 1.
- rst_n dropped during SEND_HI of a ch2 flit -> outputs go to 00 / 0 asynchronously and credits return to 8; after release, a new ch1 flit serializes normally.
